banked_arbitrated_ram: RTL and testbench
========================================

# banked_arbitrated_ram

Banked, multi-writer / multi-reader RAM: W write request ports and R read request ports share B address-interleaved banks. Each bank has its own round-robin write and read arbiters, so up to B writes and B reads complete per cycle. Each reader gets its own registered read-data return with a valid strobe. A post-reset clear sequencer optionally zeroes the array. Drop-in successor for table/lookup storage wherever several agents share one lookup structure.

## Interface
- W, 2: number of write request ports (≥1)
- R, 2: number of read request ports (≥1)
- D, 64: total depth in words; multiple of B
- B, 4: number of banks; power of 2, ≥1
- WIDTH, 32: word width; multiple of 8
- RD_FWD, 0: 0 = same-cycle read of a written address returns old data; 1 = returns byte-merged new data
- CLR_ON_RST, 1: 1 = zero all words after reset through the INIT sequence
- LOG_D / LOG_B / NBE: derived: $clog2(D), $clog2(B) (1 if B=1), WIDTH/8

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- we_i  in  W  write request per writer
- wrRdy_o  out  W  write grant; write commits in the cycle we_i & wrRdy_o
- wadr_i  in  W×LOG_D  write address per writer
- wdat_i  in  W×WIDTH  write data per writer
- wbe_i  in  W×NBE  byte enables per writer
- re_i  in  R  read request per reader
- rdRdy_o  out  R  read grant; read accepted in the cycle re_i & rdRdy_o
- radr_i  in  R×LOG_D  read address per reader
- rvld_o  out  R  read data valid, one cycle after the grant
- rdat_o  out  R×WIDTH  read data per reader, held until that reader's next return
- init_done_o  out  1  high once the array is usable

## Operation
- Bank = addr[LOG_B-1:0]; row = addr[LOG_D-1:LOG_B]. Each bank holds D/B rows.
- Per bank: the write arbiter considers writers whose wadr_i targets the bank; the read arbiter considers readers whose radr_i targets the bank. A port targets one bank, so it receives at most one grant.
- Round-robin: per-arbiter pointer, reset 0. Priority starts at the pointer index. On a grant to index k, the pointer becomes k+1 mod N. Without a grant, the pointer holds.
- Grants are combinational from the current requests (same cycle). A requester may drop its request at any time; no lock or hold requirement.
- Writes: only bytes with wbe_i set are updated. wbe_i = 0 with a grant is a legal no-op.
- FSM {INIT, RUN}:
  - rst → INIT.
  - INIT: all grants forced 0. Row counter 0..D/B-1 writes zero to that row in every bank. After the last row → RUN.
  - With CLR_ON_RST=0: INIT lasts exactly 1 cycle; the memory is not cleared.
- Reset does not clear the array other than through INIT.

## Timing
- Reset values: wrRdy_o=0, rdRdy_o=0, rvld_o=0, rdat_o=0, init_done_o=0, pointers=0, row counter=0.
- init_done_o rises in the first RUN cycle:
  - CLR_ON_RST=1: D/B+1 cycles after rst deasserts.
  - CLR_ON_RST=0: 1 cycle after rst deasserts.
- Write: data is stored at the granting clock edge. It is visible to a read granted in the next cycle.
- Read latency is 1: grant in cycle t → rvld_o=1 and rdat_o valid in t+1. rvld_o is a single-cycle pulse per grant.
- Back-to-back reads by one reader return on consecutive cycles.
- Same cycle, same address, read and write granted: RD_FWD selects old data or byte-merged new data.
- Simultaneous requests to different banks never conflict; all are granted.
- rst mid-INIT restarts the clear from row 0.
- rst mid-RUN: any pending rvld_o is dropped (0 the next cycle). Writes granted in the rst cycle do not commit, because grants are 0 during rst.

## Structure
- Shared package: bank and row index widths, the FSM state enum, and a parameter-legality check function (D % B, B power of 2, WIDTH % 8).
- One natural sub-module, rr_arb_sync (N, LOG_N): one-hot grant, grant index, synchronous active-high reset. It is instantiated 2×B times, one write and one read arbiter per bank.

## Test plan
- Reset/INIT, defaults (D=64, B=4, CLR_ON_RST=1): release rst → init_done_o rises exactly 17 cycles later with all grants 0 meanwhile. A read of every address then returns 0.
- Bank parallelism: writers 0/1 write 0xAAAA_AAAA @5 and 0x5555_5555 @6 in the same cycle → both wrRdy_o high. Reads next cycle return each value with rvld_o one cycle after grant.
- Bank conflict fairness: both writers hold requests to bank 1 for 4 cycles → grants alternate 0,1,0,1.
- Byte enables: write 0x1122_3344 @9, then write 0xFFFF_FFFF with wbe_i=4'b0101 → a read returns 0x11FF_33FF.
- Read/write collision @12: write 0xDEAD_BEEF over old 0x0000_0001 in the same cycle as a read → RD_FWD=0 returns 0x0000_0001; RD_FWD=1 returns 0xDEAD_BEEF.
- Reset mid-operation: assert rst the cycle after a read grant → rvld_o=0 next cycle. INIT re-runs and init_done_o rises after D/B+1 cycles.

Source files
------------

// File: rtl/banked_arbitrated_ram_pkg.sv
// Shared types and elaboration-time helpers for banked_arbitrated_ram.
package banked_arbitrated_ram_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Index width for n entries; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int bank_w(input int b);
    return idx_w(b);
  endfunction

  function automatic int row_w(input int d, input int b);
    return idx_w(d / b);
  endfunction

  // Depth splits evenly over a power-of-two bank count; words are whole bytes.
  function automatic bit params_ok(input int d, input int b, input int width);
    return (b >= 1) && ((d % b) == 0) && ((b & (b - 1)) == 0) && ((width % 8) == 0);
  endfunction

endpackage

// File: rtl/banked_arbitrated_ram_if.sv
// Request/return bus of banked_arbitrated_ram: W writers, R readers.
interface banked_arbitrated_ram_if
  import banked_arbitrated_ram_pkg::*;
#(
  parameter int W     = 2,
  parameter int R     = 2,
  parameter int D     = 64,
  parameter int WIDTH = 32
) ();
  localparam int LOG_D = idx_w(D);
  localparam int NBE   = WIDTH / 8;

  logic [W-1:0]                 we_i;
  logic [W-1:0]                 wrRdy_o;
  logic [W-1:0][LOG_D-1:0]      wadr_i;
  logic [W-1:0][WIDTH-1:0]      wdat_i;
  logic [W-1:0][NBE-1:0]        wbe_i;
  logic [R-1:0]                 re_i;
  logic [R-1:0]                 rdRdy_o;
  logic [R-1:0][LOG_D-1:0]      radr_i;
  logic [R-1:0]                 rvld_o;
  logic [R-1:0][WIDTH-1:0]      rdat_o;
  logic                         init_done_o;

  modport slave (
    input  we_i, wadr_i, wdat_i, wbe_i, re_i, radr_i,
    output wrRdy_o, rdRdy_o, rvld_o, rdat_o, init_done_o
  );

  modport master (
    output we_i, wadr_i, wdat_i, wbe_i, re_i, radr_i,
    input  wrRdy_o, rdRdy_o, rvld_o, rdat_o, init_done_o
  );
endinterface

// File: rtl/banked_arbitrated_ram_rr_arb_sync.sv
// Round-robin arbiter: same-cycle one-hot grant, pointer advances past the winner.
module rr_arb_sync #(
  parameter int N     = 2,
  parameter int LOG_N = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     i_req,
  output logic [N-1:0]     o_gnt,
  output logic [LOG_N-1:0] o_idx,
  output logic             o_any
);
  logic [LOG_N-1:0] r_ptr;

  // First requester at or above the pointer wins; otherwise wrap to the lowest one.
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!o_any && i_req[k] && (k >= int'(r_ptr))) begin
        o_any    = 1'b1;
        o_idx    = LOG_N'(k);
        o_gnt[k] = 1'b1;
      end
    end
    for (int k = 0; k < N; k++) begin
      if (!o_any && i_req[k] && (k < int'(r_ptr))) begin
        o_any    = 1'b1;
        o_idx    = LOG_N'(k);
        o_gnt[k] = 1'b1;
      end
    end
  end

  // Pointer moves to winner+1 (mod N); holds when nobody is granted.
  always_ff @(posedge clk) begin
    if (rst)        r_ptr <= '0;
    else if (o_any) r_ptr <= (o_idx == LOG_N'(N - 1)) ? '0 : o_idx + 1'b1;
  end
endmodule

// File: rtl/banked_arbitrated_ram.sv
// Multi-writer / multi-reader RAM over B address-interleaved banks with
// per-bank round-robin arbitration and a post-reset clear sequence.
module banked_arbitrated_ram
  import banked_arbitrated_ram_pkg::*;
#(
  parameter int W          = 2,
  parameter int R          = 2,
  parameter int D          = 64,
  parameter int B          = 4,
  parameter int WIDTH      = 32,
  parameter int RD_FWD     = 0,
  parameter int CLR_ON_RST = 1
) (
  input logic                    clk,
  input logic                    rst,
  banked_arbitrated_ram_if.slave bus
);
  localparam int LOG_D   = idx_w(D);
  localparam int LOG_B   = bank_w(B);
  localparam int SH      = (B > 1) ? $clog2(B) : 0;
  localparam int ROWS    = D / B;
  localparam int LOG_ROW = row_w(D, B);
  localparam int NBE     = WIDTH / 8;
  localparam int LOG_W   = idx_w(W);
  localparam int LOG_R   = idx_w(R);
  localparam int CNT_W   = $clog2(ROWS + 1);

  if (!params_ok(D, B, WIDTH)) begin : g_param_err
    $error("banked_arbitrated_ram: illegal D/B/WIDTH combination");
  end

  state_e                        r_state, w_nstate;
  logic [CNT_W-1:0]              r_row, w_nrow;
  logic                          w_run, w_clr;
  logic [W-1:0][LOG_B-1:0]       w_wbank;
  logic [W-1:0][LOG_ROW-1:0]     w_wrow;
  logic [R-1:0][LOG_B-1:0]       w_rbank;
  logic [R-1:0][LOG_ROW-1:0]     w_rrow;
  logic [B-1:0][W-1:0]           w_bank_wgnt;
  logic [B-1:0][R-1:0]           w_bank_rgnt;
  logic [B-1:0][WIDTH-1:0]       w_bank_rdat;
  logic [W-1:0]                  w_wr_rdy;
  logic [R-1:0]                  w_rd_rdy;
  logic [R-1:0]                  r_rvld;
  logic [R-1:0][WIDTH-1:0]       r_rdat;

  // Grants are only possible in RUN and never in a reset cycle.
  assign w_run = (r_state == ST_RUN) && !rst;
  assign w_clr = (CLR_ON_RST != 0) && (r_state == ST_INIT) && !rst && (r_row < CNT_W'(ROWS));

  // State register and clear-row counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_INIT;
      r_row   <= '0;
    end else begin
      r_state <= w_nstate;
      r_row   <= w_nrow;
    end
  end

  // INIT walks rows 0..ROWS-1, then one more cycle before RUN.
  always_comb begin
    w_nstate = r_state;
    w_nrow   = r_row;
    if (r_state == ST_INIT) begin
      if ((CLR_ON_RST == 0) || (r_row == CNT_W'(ROWS))) begin
        w_nstate = ST_RUN;
        w_nrow   = '0;
      end else begin
        w_nrow = r_row + 1'b1;
      end
    end
  end

  // Low address bits pick the bank, the rest pick the row.
  always_comb begin
    for (int w = 0; w < W; w++) begin
      w_wbank[w] = LOG_B'(bus.wadr_i[w] & LOG_D'(B - 1));
      w_wrow[w]  = LOG_ROW'(bus.wadr_i[w] >> SH);
    end
    for (int r = 0; r < R; r++) begin
      w_rbank[r] = LOG_B'(bus.radr_i[r] & LOG_D'(B - 1));
      w_rrow[r]  = LOG_ROW'(bus.radr_i[r] >> SH);
    end
  end

  for (genvar b = 0; b < B; b++) begin : g_bank
    logic [W-1:0]         w_wreq, w_wgnt;
    logic [LOG_W-1:0]     w_widx;
    logic                 w_wany;
    logic [R-1:0]         w_rreq, w_rgnt;
    logic [LOG_R-1:0]     w_ridx;
    logic                 w_rany;
    logic [LOG_ROW-1:0]   w_wr_row, w_rd_row;
    logic [WIDTH-1:0]     w_rdat;
    logic [WIDTH-1:0]     r_mem [ROWS];

    // Requests that target this bank.
    always_comb begin
      for (int w = 0; w < W; w++) w_wreq[w] = w_run & bus.we_i[w] & (w_wbank[w] == LOG_B'(b));
      for (int r = 0; r < R; r++) w_rreq[r] = w_run & bus.re_i[r] & (w_rbank[r] == LOG_B'(b));
    end

    rr_arb_sync #(.N(W), .LOG_N(LOG_W)) u_warb (
      .clk(clk), .rst(rst), .i_req(w_wreq), .o_gnt(w_wgnt), .o_idx(w_widx), .o_any(w_wany)
    );
    rr_arb_sync #(.N(R), .LOG_N(LOG_R)) u_rarb (
      .clk(clk), .rst(rst), .i_req(w_rreq), .o_gnt(w_rgnt), .o_idx(w_ridx), .o_any(w_rany)
    );

    assign w_wr_row       = w_wrow[w_widx];
    assign w_rd_row       = w_rrow[w_ridx];
    assign w_bank_wgnt[b] = w_wgnt;
    assign w_bank_rgnt[b] = w_rgnt;
    assign w_bank_rdat[b] = w_rdat;

    // Clear row during INIT; otherwise the winning writer's enabled bytes.
    always_ff @(posedge clk) begin
      if (w_clr) begin
        r_mem[r_row[LOG_ROW-1:0]] <= '0;
      end else if (w_wany) begin
        for (int k = 0; k < NBE; k++)
          if (bus.wbe_i[w_widx][k]) r_mem[w_wr_row][8*k +: 8] <= bus.wdat_i[w_widx][8*k +: 8];
      end
    end

    // Read port of this bank; optionally merges a same-row write landing this cycle.
    always_comb begin
      w_rdat = r_mem[w_rd_row];
      if ((RD_FWD != 0) && w_rany && w_wany && (w_wr_row == w_rd_row)) begin
        for (int k = 0; k < NBE; k++)
          if (bus.wbe_i[w_widx][k]) w_rdat[8*k +: 8] = bus.wdat_i[w_widx][8*k +: 8];
      end
    end
  end

  // Each port targets one bank, so OR-ing per-bank grants gives the port grant.
  always_comb begin
    w_wr_rdy = '0;
    w_rd_rdy = '0;
    for (int b = 0; b < B; b++) begin
      w_wr_rdy = w_wr_rdy | w_bank_wgnt[b];
      w_rd_rdy = w_rd_rdy | w_bank_rgnt[b];
    end
  end

  // Registered read return per reader; data holds until that reader's next grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rvld <= '0;
      r_rdat <= '0;
    end else begin
      for (int r = 0; r < R; r++) begin
        r_rvld[r] <= w_rd_rdy[r];
        if (w_rd_rdy[r]) r_rdat[r] <= w_bank_rdat[w_rbank[r]];
      end
    end
  end

  assign bus.wrRdy_o     = w_wr_rdy;
  assign bus.rdRdy_o     = w_rd_rdy;
  assign bus.rvld_o      = r_rvld;
  assign bus.rdat_o      = r_rdat;
  assign bus.init_done_o = (r_state == ST_RUN);
endmodule

// File: tb/tb_banked_arbitrated_ram.sv
// Bench: two instances (old-data and forwarding read) share stimulus and a
// flat-array reference model; directed cases pin the model with literals.
module tb_banked_arbitrated_ram;
  localparam int W = 2, R = 2, D = 64, B = 4, WIDTH = 32, NBE = WIDTH / 8, ROWS = D / B;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  banked_arbitrated_ram_if #(.W(W), .R(R), .D(D), .WIDTH(WIDTH)) if0 ();
  banked_arbitrated_ram_if #(.W(W), .R(R), .D(D), .WIDTH(WIDTH)) if1 ();

  assign if1.we_i   = if0.we_i;
  assign if1.wadr_i = if0.wadr_i;
  assign if1.wdat_i = if0.wdat_i;
  assign if1.wbe_i  = if0.wbe_i;
  assign if1.re_i   = if0.re_i;
  assign if1.radr_i = if0.radr_i;

  banked_arbitrated_ram #(.W(W), .R(R), .D(D), .B(B), .WIDTH(WIDTH), .RD_FWD(0), .CLR_ON_RST(1))
    dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
  banked_arbitrated_ram #(.W(W), .R(R), .D(D), .B(B), .WIDTH(WIDTH), .RD_FWD(1), .CLR_ON_RST(1))
    dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

  // reference state
  logic [WIDTH-1:0] mem [D];
  int               wp [B];
  int               rp [B];
  int               m_since;
  logic [R-1:0]     m_rvld;
  logic [WIDTH-1:0] m_rd0 [R];
  logic [WIDTH-1:0] m_rd1 [R];
  int               n_chk, n_err;
  logic [W-1:0]     s_wg;
  logic [R-1:0]     s_rg;
  int               n;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] merge(input logic [WIDTH-1:0] old, input logic [WIDTH-1:0] nw,
                                             input logic [NBE-1:0] be);
    logic [WIDTH-1:0] v;
    v = old;
    for (int k = 0; k < NBE; k++) if (be[k]) v[8*k +: 8] = nw[8*k +: 8];
    return v;
  endfunction

  task automatic idle();
    if0.we_i = '0; if0.re_i = '0;
    for (int w = 0; w < W; w++) begin
      if0.wadr_i[w] = '0; if0.wdat_i[w] = '0; if0.wbe_i[w] = '0;
    end
    for (int r = 0; r < R; r++) if0.radr_i[r] = '0;
  endtask

  task automatic rnd();
    if0.we_i = W'($urandom);
    if0.re_i = R'($urandom);
    for (int w = 0; w < W; w++) begin
      if0.wadr_i[w] = 6'($urandom_range(0, D - 1));
      if0.wdat_i[w] = $urandom;
      if0.wbe_i[w]  = NBE'($urandom);
    end
    for (int r = 0; r < R; r++) if0.radr_i[r] = 6'($urandom_range(0, D - 1));
  endtask

  // One cycle: compare at the falling edge, then advance the model to the next rising edge.
  task automatic tick();
    logic [W-1:0] eg;
    logic [R-1:0] er;
    bit           run, got;
    int           k, a;
    int           nwp [B];
    int           nrp [B];
    @(negedge clk);
    run = !rst && (m_since > ROWS);
    eg = '0; er = '0;
    for (int b = 0; b < B; b++) begin
      nwp[b] = wp[b]; nrp[b] = rp[b];
      if (run) begin
        got = 0;
        for (int i = 0; i < W; i++) begin
          k = (wp[b] + i) % W;
          if (!got && if0.we_i[k] && (int'(if0.wadr_i[k]) % B == b)) begin
            got = 1; eg[k] = 1'b1; nwp[b] = (k + 1) % W;
          end
        end
        got = 0;
        for (int i = 0; i < R; i++) begin
          k = (rp[b] + i) % R;
          if (!got && if0.re_i[k] && (int'(if0.radr_i[k]) % B == b)) begin
            got = 1; er[k] = 1'b1; nrp[b] = (k + 1) % R;
          end
        end
      end
    end
    chk("init_done0", if0.init_done_o, m_since > ROWS);
    chk("init_done1", if1.init_done_o, m_since > ROWS);
    chk("wrRdy0", if0.wrRdy_o, eg);
    chk("wrRdy1", if1.wrRdy_o, eg);
    chk("rdRdy0", if0.rdRdy_o, er);
    chk("rdRdy1", if1.rdRdy_o, er);
    chk("rvld0", if0.rvld_o, m_rvld);
    chk("rvld1", if1.rvld_o, m_rvld);
    for (int r = 0; r < R; r++) begin
      chk("rdat_old", if0.rdat_o[r], m_rd0[r]);
      chk("rdat_fwd", if1.rdat_o[r], m_rd1[r]);
    end
    s_wg = if0.wrRdy_o;
    s_rg = if0.rdRdy_o;
    if (rst) begin
      m_since = 0;
      m_rvld  = '0;
      for (int r = 0; r < R; r++) begin m_rd0[r] = '0; m_rd1[r] = '0; end
      for (int b = 0; b < B; b++) begin wp[b] = 0; rp[b] = 0; end
      for (int i = 0; i < D; i++) mem[i] = '0;
    end else begin
      for (int r = 0; r < R; r++) begin
        if (er[r]) begin
          a = int'(if0.radr_i[r]);
          m_rd0[r] = mem[a];
          m_rd1[r] = mem[a];
          for (int w = 0; w < W; w++)
            if (eg[w] && int'(if0.wadr_i[w]) == a) m_rd1[r] = merge(mem[a], if0.wdat_i[w], if0.wbe_i[w]);
        end
      end
      m_rvld = er;
      for (int w = 0; w < W; w++)
        if (eg[w]) mem[if0.wadr_i[w]] = merge(mem[if0.wadr_i[w]], if0.wdat_i[w], if0.wbe_i[w]);
      for (int b = 0; b < B; b++) begin wp[b] = nwp[b]; rp[b] = nrp[b]; end
      if (m_since <= ROWS) m_since++;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk = 0; n_err = 0; m_since = 0; m_rvld = '0; s_wg = '0; s_rg = '0;
    for (int i = 0; i < D; i++) mem[i] = '0;
    for (int b = 0; b < B; b++) begin wp[b] = 0; rp[b] = 0; end
    for (int r = 0; r < R; r++) begin m_rd0[r] = '0; m_rd1[r] = '0; end
    idle();
    rst = 1'b1;
    repeat (3) tick();
    chk("rst_rvld", if0.rvld_o, 0);
    chk("rst_rdat", if0.rdat_o, 0);
    chk("rst_done", if0.init_done_o, 0);

    // release reset with random traffic during INIT; grants must stay 0
    rst = 1'b0; n = 0;
    while (!if0.init_done_o && n < 40) begin rnd(); tick(); n++; end
    chk("init_latency", n, 17);

    // every word reads back as zero after the clear
    idle();
    for (int a = 0; a < D; a += 2) begin
      if0.re_i = 2'b11; if0.radr_i[0] = 6'(a); if0.radr_i[1] = 6'(a + 1);
      tick();
    end
    idle();
    chk("sweep_last", if0.rdat_o[1], 0);
    tick();

    // two writers on bank 1: grants alternate starting at writer 0
    idle();
    if0.we_i = 2'b11; if0.wadr_i[0] = 6'd1; if0.wadr_i[1] = 6'd5;
    if0.wbe_i[0] = 4'hF; if0.wbe_i[1] = 4'hF;
    for (int i = 0; i < 4; i++) begin
      if0.wdat_i[0] = $urandom; if0.wdat_i[1] = $urandom;
      tick();
      chk("fair", s_wg, (i % 2 == 0) ? 2'b01 : 2'b10);
    end

    // different banks proceed in parallel
    idle();
    if0.we_i = 2'b11;
    if0.wadr_i[0] = 6'd5; if0.wdat_i[0] = 32'hAAAA_AAAA; if0.wbe_i[0] = 4'hF;
    if0.wadr_i[1] = 6'd6; if0.wdat_i[1] = 32'h5555_5555; if0.wbe_i[1] = 4'hF;
    tick();
    chk("par_wgnt", s_wg, 2'b11);
    idle();
    if0.re_i = 2'b11; if0.radr_i[0] = 6'd5; if0.radr_i[1] = 6'd6;
    tick();
    chk("par_rgnt", s_rg, 2'b11);
    idle();
    chk("par_rvld", if0.rvld_o, 2'b11);
    chk("par_rdat0", if0.rdat_o[0], 32'hAAAA_AAAA);
    chk("par_rdat1", if0.rdat_o[1], 32'h5555_5555);
    tick();

    // byte enables
    idle();
    if0.we_i = 2'b01; if0.wadr_i[0] = 6'd9; if0.wdat_i[0] = 32'h1122_3344; if0.wbe_i[0] = 4'hF;
    tick();
    if0.wdat_i[0] = 32'hFFFF_FFFF; if0.wbe_i[0] = 4'b0101;
    tick();
    idle();
    if0.re_i = 2'b01; if0.radr_i[0] = 6'd9;
    tick();
    idle();
    chk("be_rdat", if0.rdat_o[0], 32'h11FF_33FF);

    // same-cycle read and write of one address
    if0.we_i = 2'b01; if0.wadr_i[0] = 6'd12; if0.wdat_i[0] = 32'h0000_0001; if0.wbe_i[0] = 4'hF;
    tick();
    idle();
    if0.we_i = 2'b10; if0.wadr_i[1] = 6'd12; if0.wdat_i[1] = 32'hDEAD_BEEF; if0.wbe_i[1] = 4'hF;
    if0.re_i = 2'b01; if0.radr_i[0] = 6'd12;
    tick();
    idle();
    chk("col_old", if0.rdat_o[0], 32'h0000_0001);
    chk("col_fwd", if1.rdat_o[0], 32'hDEAD_BEEF);

    // random traffic
    repeat (500) begin rnd(); tick(); end

    // reset the cycle after a read grant
    idle();
    if0.re_i = 2'b01; if0.radr_i[0] = 6'd3;
    tick();
    rst = 1'b1;
    if0.we_i = 2'b01; if0.wadr_i[0] = 6'd3; if0.wdat_i[0] = 32'hCAFE_F00D; if0.wbe_i[0] = 4'hF;
    tick();
    chk("rst_rvld_drop", if0.rvld_o, 0);
    chk("rst_wgnt", s_wg, 0);
    rst = 1'b0; n = 0;
    idle();
    while (!if0.init_done_o && n < 40) begin tick(); n++; end
    chk("reinit_latency", n, 17);
    if0.re_i = 2'b01; if0.radr_i[0] = 6'd3;
    tick();
    idle();
    chk("rst_no_commit", if0.rdat_o[0], 0);
    repeat (100) begin rnd(); tick(); end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
